thread_scheduler: RTL and testbench
===================================

// Module: thread_scheduler
// PURPOSE
//  Barrel-core issue controller: each cycle picks one runnable hardware thread, round-robin,
//  and drives its tid and PC into fetch. Keeps per-thread run state, a per-thread PC table and a
//  re-issue cooldown, so a thread never has two instructions in flight in the same stage window.
//  Sits ahead of the F/D pipeline register. tid then travels down the pipe (E/M reg tid_e -> tid_m).
// PARAMETERS
//  BITS_THREADS   3        thread-id width; NUM_THREADS = 1<<BITS_THREADS
//  ADDRESS_WIDTH  32       PC width
//  RESET_PC       32'h0    PC loaded into every thread on reset
//  MIN_GAP        5        min issue slots between two issues of one thread (>=1)
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              async active-low reset
//  stall_i       in   1              global pipeline stall; freezes issue, rr pointer, PCs, cooldowns
//  start_i       in   NUM_THREADS    per-thread start pulse (IDLE->RUN)
//  block_valid_i in   1              thread block_tid_i waits on long-latency op (RUN->WAIT)
//  block_tid_i   in   BITS_THREADS
//  wake_valid_i  in   1              thread wake_tid_i resumes (WAIT->RUN)
//  wake_tid_i    in   BITS_THREADS
//  halt_valid_i  in   1              thread halt_tid_i retires for good (->HALT)
//  halt_tid_i    in   BITS_THREADS
//  redir_valid_i in   1              PC redirect (branch/jump resolved in E)
//  redir_tid_i   in   BITS_THREADS
//  redir_pc_i    in   ADDRESS_WIDTH
//  issue_valid_o out  1              registered; issue_tid_o/issue_pc_o valid this cycle
//  issue_tid_o   out  BITS_THREADS   registered
//  issue_pc_o    out  ADDRESS_WIDTH  registered
//  bubble_o      out  1              registered; = ~issue_valid_o, drives F/D clr
//  run_mask_o    out  NUM_THREADS    registered; bit t = thread t in RUN
//  all_halted_o  out  1              registered; every thread in HALT
// BEHAVIOUR
//  Reset (async, rst_n=0): all threads IDLE, pc[t]=RESET_PC, cooldown[t]=0, rr_ptr=NUM_THREADS-1
//   (tid 0 gets first priority); issue_valid_o=0, issue_tid_o=0, issue_pc_o=0, bubble_o=1,
//   run_mask_o=0, all_halted_o=0. Reset mid-operation drops any in-flight issue immediately.
//  Thread FSM, evaluated every edge, stall or not. Priority halt > wake > block > start:
//   IDLE -start_i[t]-> RUN; RUN -block-> WAIT; WAIT -wake-> RUN; RUN/WAIT/IDLE -halt-> HALT.
//   HALT is terminal until reset. Block on a non-RUN thread and wake on a non-WAIT thread are ignored.
//   Block and wake for the same tid in one cycle: wake wins (thread stays or becomes RUN).
//  Eligibility (combinational): state==RUN && cooldown==0 && !(block or halt for t this cycle).
//  Selection: first eligible tid scanning rr_ptr+1, rr_ptr+2, ... with wrap mod NUM_THREADS.
//  On edge with stall_i=0:
//   - eligible thread found: issue_valid_o<=1, issue_tid_o<=t, issue_pc_o<=pc[t] (redir_pc_i if
//     same-cycle redirect for t), pc[t]<=that value + 4, rr_ptr<=t, cooldown[t]<=MIN_GAP-1.
//   - none found: issue_valid_o<=0 (bubble), rr_ptr unchanged.
//   - every nonzero cooldown decrements by 1 (not the one just loaded).
//  On edge with stall_i=1: issue outputs, rr_ptr, cooldowns hold. PC redirects still land.
//  Redirect for a non-issued tid: pc[t]<=redir_pc_i. Redirect to HALT/IDLE thread is still written.
//  PC arithmetic is modulo 2^ADDRESS_WIDTH (wrap, no flag).
//  Latency: selection in cycle N -> outputs valid in cycle N+1. Start -> earliest issue 1 cycle later.
//  run_mask_o/all_halted_o reflect the post-edge FSM state.
// STRUCTURE
//  barrel_pkg: thread-state encoding (IDLE=0, RUN=1, WAIT=2, HALT=3), NUM_THREADS, RESET_PC,
//   shared with the pipeline regs (tid width).
//  Sub-module rr_arbiter #(N): rotating-priority one-hot/encoded grant from req mask + rr_ptr.
//  Top holds the FSM array, PC table, cooldown counters and output registers.
// TESTING
//  1. Reset, start_i=8'hFF, no stall -> tids 0,1,...,7,0 on consecutive cycles, pc +4 per re-issue.
//  2. Only thread 2 started, MIN_GAP=5 -> tid 2 issues every 5th cycle, 4 bubbles between (bubble_o=1).
//  3. All running, block tid 3 -> tid 3 skipped until wake; block+wake same cycle -> tid 3 never skipped.
//  4. Redirect tid 1 to 32'h100 the same cycle it is selected -> issue_pc_o=32'h100, next pc 32'h104.
//  5. stall_i high 3 cycles mid-stream -> outputs frozen, order and cooldowns resume exactly.
//  6. Halt all threads -> all_halted_o=1, issue_valid_o=0. Async rst_n mid-issue -> outputs 0 at once.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// rtl/thread_scheduler_pkg.sv - shared thread-state encoding and default sizing for the barrel core
// Purpose: thread run-state enum and the default thread count, PC width, reset PC and
//          re-issue gap, shared by the scheduler and the pipeline registers that carry tid.
// Ports:   none (package).
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_WAIT = 2'd2,
    TS_HALT = 2'd3
  } thread_state_e;

  localparam int          TS_BITS_THREADS  = 3;
  localparam int          TS_NUM_THREADS   = 1 << TS_BITS_THREADS;
  localparam int          TS_ADDRESS_WIDTH = 32;
  localparam logic [31:0] TS_RESET_PC      = 32'h0;
  localparam int          TS_MIN_GAP       = 5;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// rtl/thread_scheduler_rr_arbiter.sv - rotating-priority arbiter over N request lines
// Purpose: grants the first requester found scanning ptr_i+1, ptr_i+2, ... modulo N.
// Ports:   req_i       request mask
//          ptr_i       last granted index (highest priority goes to ptr_i+1)
//          gnt_valid_o any requester granted
//          gnt_oh_o    one-hot grant
//          gnt_idx_o   encoded grant (0 when gnt_valid_o=0)
module rr_arbiter #(
  parameter int  N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         gnt_valid_o,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o
);

  logic [W-1:0] idx;

  // N is a power of two, so W-bit addition wraps naturally; i=N lands back on ptr_i.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ptr_i + W'(i);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
    gnt_oh_o            = '0;
    gnt_oh_o[gnt_idx_o] = gnt_valid_o;
  end

endmodule

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - barrel-core issue controller, one runnable thread per cycle round-robin
// Purpose: keeps per-thread run state, PC table and re-issue cooldown; each unstalled edge issues
//          the next eligible thread's tid and PC toward fetch.
// Ports:   clk, rst_n                   clock, async active-low reset
//          stall_i                      freezes issue outputs, rr pointer, PCs and cooldowns
//          start_i[t]                   IDLE -> RUN
//          block_valid_i/block_tid_i    RUN -> WAIT
//          wake_valid_i/wake_tid_i      WAIT -> RUN
//          halt_valid_i/halt_tid_i      any -> HALT (terminal)
//          redir_valid_i/tid/pc         PC redirect for one thread
//          issue_valid_o/tid_o/pc_o     registered issue slot
//          bubble_o                     registered ~issue_valid_o
//          run_mask_o                   registered per-thread RUN flags
//          all_halted_o                 registered, every thread HALT
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int                       BITS_THREADS  = TS_BITS_THREADS,
  parameter int                       ADDRESS_WIDTH = TS_ADDRESS_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(TS_RESET_PC),
  parameter int                       MIN_GAP       = TS_MIN_GAP,
  localparam int                      NUM_THREADS   = 1 << BITS_THREADS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic [NUM_THREADS-1:0]   start_i,
  input  logic                     block_valid_i,
  input  logic [BITS_THREADS-1:0]  block_tid_i,
  input  logic                     wake_valid_i,
  input  logic [BITS_THREADS-1:0]  wake_tid_i,
  input  logic                     halt_valid_i,
  input  logic [BITS_THREADS-1:0]  halt_tid_i,
  input  logic                     redir_valid_i,
  input  logic [BITS_THREADS-1:0]  redir_tid_i,
  input  logic [ADDRESS_WIDTH-1:0] redir_pc_i,
  output logic                     issue_valid_o,
  output logic [BITS_THREADS-1:0]  issue_tid_o,
  output logic [ADDRESS_WIDTH-1:0] issue_pc_o,
  output logic                     bubble_o,
  output logic [NUM_THREADS-1:0]   run_mask_o,
  output logic                     all_halted_o
);

  localparam int              CD_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MIN_GAP - 1);

  thread_state_e              state_q [NUM_THREADS];
  thread_state_e              state_d [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0]   pc_q    [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0]   pc_d    [NUM_THREADS];
  logic [CD_W-1:0]            cd_q    [NUM_THREADS];
  logic [CD_W-1:0]            cd_d    [NUM_THREADS];
  logic [BITS_THREADS-1:0]    rr_ptr_q, rr_ptr_d;
  logic                       issue_valid_q, issue_valid_d;
  logic [BITS_THREADS-1:0]    issue_tid_q, issue_tid_d;
  logic [ADDRESS_WIDTH-1:0]   issue_pc_q, issue_pc_d;
  logic                       bubble_q, bubble_d;
  logic [NUM_THREADS-1:0]     run_mask_q, run_mask_d;
  logic                       all_halted_q, all_halted_d;

  logic [NUM_THREADS-1:0]     halt_hit, wake_hit, block_hit, redir_hit, eligible, halted_bits;
  logic                       gnt_valid;
  logic [NUM_THREADS-1:0]     gnt_oh;
  logic [BITS_THREADS-1:0]    gnt_idx;
  logic [ADDRESS_WIDTH-1:0]   issue_base;

  // Per-thread event decode. A same-cycle wake cancels a block for that tid, so the
  // thread neither leaves RUN nor loses its issue slot.
  always_comb begin
    halt_hit  = '0;
    wake_hit  = '0;
    block_hit = '0;
    redir_hit = '0;
    eligible  = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      halt_hit[t]  = halt_valid_i  && (halt_tid_i  == BITS_THREADS'(t));
      wake_hit[t]  = wake_valid_i  && (wake_tid_i  == BITS_THREADS'(t));
      block_hit[t] = block_valid_i && (block_tid_i == BITS_THREADS'(t)) && !wake_hit[t];
      redir_hit[t] = redir_valid_i && (redir_tid_i == BITS_THREADS'(t));
      eligible[t]  = (state_q[t] == TS_RUN) && (cd_q[t] == '0) && !block_hit[t] && !halt_hit[t];
    end
  end

  rr_arbiter #(.N(NUM_THREADS)) u_rr_arbiter (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_oh_o    (gnt_oh),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
      cd_d[t]    = cd_q[t];
    end
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_tid_d   = issue_tid_q;
    issue_pc_d    = issue_pc_q;
    halted_bits   = '0;
    run_mask_d    = '0;

    // A redirect arriving for the thread being issued replaces its PC for this issue.
    issue_base = (redir_valid_i && (redir_tid_i == gnt_idx)) ? redir_pc_i : pc_q[gnt_idx];

    // Thread FSMs and redirects advance regardless of stall.
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (halt_hit[t]) begin
        state_d[t] = TS_HALT;
      end else begin
        case (state_q[t])
          TS_IDLE: if (start_i[t])   state_d[t] = TS_RUN;
          TS_RUN:  if (block_hit[t]) state_d[t] = TS_WAIT;
          TS_WAIT: if (wake_hit[t])  state_d[t] = TS_RUN;
          default: state_d[t] = state_q[t];
        endcase
      end
      if (redir_hit[t]) pc_d[t] = redir_pc_i;
    end

    if (!stall_i) begin
      issue_valid_d = gnt_valid;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (gnt_oh[t]) begin
          cd_d[t] = CD_LOAD;
          pc_d[t] = issue_base + ADDRESS_WIDTH'(4);
        end else if (cd_q[t] != '0) begin
          cd_d[t] = cd_q[t] - CD_W'(1);
        end
      end
      if (gnt_valid) begin
        rr_ptr_d    = gnt_idx;
        issue_tid_d = gnt_idx;
        issue_pc_d  = issue_base;
      end
    end

    bubble_d = ~issue_valid_d;
    for (int t = 0; t < NUM_THREADS; t++) begin
      run_mask_d[t]  = (state_d[t] == TS_RUN);
      halted_bits[t] = (state_d[t] == TS_HALT);
    end
    all_halted_d = &halted_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= TS_IDLE;
        pc_q[t]    <= RESET_PC;
        cd_q[t]    <= '0;
      end
      rr_ptr_q      <= BITS_THREADS'(NUM_THREADS - 1);
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      issue_pc_q    <= '0;
      bubble_q      <= 1'b1;
      run_mask_q    <= '0;
      all_halted_q  <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
        cd_q[t]    <= cd_d[t];
      end
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      issue_pc_q    <= issue_pc_d;
      bubble_q      <= bubble_d;
      run_mask_q    <= run_mask_d;
      all_halted_q  <= all_halted_d;
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_tid_o   = issue_tid_q;
  assign issue_pc_o    = issue_pc_q;
  assign bubble_o      = bubble_q;
  assign run_mask_o    = run_mask_q;
  assign all_halted_o  = all_halted_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - directed vector bench for thread_scheduler
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic [7:0]  start_i = '0;
  logic        block_valid_i = 1'b0;
  logic [2:0]  block_tid_i = '0;
  logic        wake_valid_i = 1'b0;
  logic [2:0]  wake_tid_i = '0;
  logic        halt_valid_i = 1'b0;
  logic [2:0]  halt_tid_i = '0;
  logic        redir_valid_i = 1'b0;
  logic [2:0]  redir_tid_i = '0;
  logic [31:0] redir_pc_i = '0;
  logic        issue_valid_o;
  logic [2:0]  issue_tid_o;
  logic [31:0] issue_pc_o;
  logic        bubble_o;
  logic [7:0]  run_mask_o;
  logic        all_halted_o;

  always #5 clk = ~clk;

  thread_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .start_i       (start_i),
    .block_valid_i (block_valid_i),
    .block_tid_i   (block_tid_i),
    .wake_valid_i  (wake_valid_i),
    .wake_tid_i    (wake_tid_i),
    .halt_valid_i  (halt_valid_i),
    .halt_tid_i    (halt_tid_i),
    .redir_valid_i (redir_valid_i),
    .redir_tid_i   (redir_tid_i),
    .redir_pc_i    (redir_pc_i),
    .issue_valid_o (issue_valid_o),
    .issue_tid_o   (issue_tid_o),
    .issue_pc_o    (issue_pc_o),
    .bubble_o      (bubble_o),
    .run_mask_o    (run_mask_o),
    .all_halted_o  (all_halted_o)
  );

  // Event fields blk/wak/hlt/rd are {valid, tid[2:0]}; 0 means no event.
  typedef struct {
    logic        rst;
    logic        stall;
    logic [7:0]  start;
    logic [3:0]  blk;
    logic [3:0]  wak;
    logic [3:0]  hlt;
    logic [3:0]  rd;
    logic [31:0] rdpc;
    logic        ev;
    logic [2:0]  et;
    logic [31:0] ep;
    logic [7:0]  em;
    logic        eh;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int stall, input int start, input int blk, input int wak,
                     input int hlt, input int rd, input int rdpc, input int ev, input int et,
                     input int ep, input int em, input int eh);
    vec_t v;
    v.rst = 1'(rst);  v.stall = 1'(stall); v.start = 8'(start);
    v.blk = 4'(blk);  v.wak = 4'(wak);     v.hlt = 4'(hlt);  v.rd = 4'(rd);
    v.rdpc = 32'(rdpc);
    v.ev = 1'(ev);    v.et = 3'(et);       v.ep = 32'(ep);   v.em = 8'(em); v.eh = 1'(eh);
    vecs.push_back(v);
  endtask

  task automatic iss(input int t, input int pc, input int m);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, t, pc, m, 0);
  endtask

  task automatic bub(input int m, input int h);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m, h);
  endtask

  task automatic clear_inputs();
    stall_i = 1'b0; start_i = '0;
    block_valid_i = 1'b0; block_tid_i = '0;
    wake_valid_i = 1'b0;  wake_tid_i = '0;
    halt_valid_i = 1'b0;  halt_tid_i = '0;
    redir_valid_i = 1'b0; redir_tid_i = '0; redir_pc_i = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " valid"},  32'(issue_valid_o), 32'h0);
    chk({tag, " bubble"}, 32'(bubble_o),      32'h1);
    chk({tag, " tid"},    32'(issue_tid_o),   32'h0);
    chk({tag, " pc"},     issue_pc_o,         32'h0);
    chk({tag, " mask"},   32'(run_mask_o),    32'h0);
    chk({tag, " halted"}, 32'(all_halted_o),  32'h0);
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    stall_i       = v.stall;
    start_i       = v.start;
    block_valid_i = v.blk[3]; block_tid_i = v.blk[2:0];
    wake_valid_i  = v.wak[3]; wake_tid_i  = v.wak[2:0];
    halt_valid_i  = v.hlt[3]; halt_tid_i  = v.hlt[2:0];
    redir_valid_i = v.rd[3];  redir_tid_i = v.rd[2:0];
    redir_pc_i    = v.rdpc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    // Phase A: all threads, round robin, redirects, block/wake.
    add(1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 0);
    for (int t = 0; t < 8; t++) iss(t, 0, 'hFF);
    iss(0, 'h4, 'hFF);
    add(0, 0, 0, 0, 0, 0, 'h9, 'h100, 1, 1, 'h100, 'hFF, 0);   // redirect tid1 as it issues
    add(0, 0, 0, 0, 0, 0, 'hD, 'h200, 1, 2, 'h4, 'hFF, 0);     // redirect idle-slot tid5
    iss(3, 'h4, 'hFF);   iss(4, 'h4, 'hFF);   iss(5, 'h200, 'hFF); iss(6, 'h4, 'hFF);
    iss(7, 'h4, 'hFF);   iss(0, 'h8, 'hFF);   iss(1, 'h104, 'hFF); iss(2, 'h8, 'hFF);
    iss(3, 'h8, 'hFF);   iss(4, 'h8, 'hFF);   iss(5, 'h204, 'hFF);
    add(0, 0, 0, 'hB, 0, 0, 0, 0, 1, 6, 'h8, 'hF7, 0);         // block tid3
    iss(7, 'h8, 'hF7);   iss(0, 'hC, 'hF7);   iss(1, 'h108, 'hF7); iss(2, 'hC, 'hF7);
    iss(4, 'hC, 'hF7);   iss(5, 'h208, 'hF7); iss(6, 'hC, 'hF7);   iss(7, 'hC, 'hF7);
    add(0, 0, 0, 0, 'hB, 0, 0, 0, 1, 0, 'h10, 'hFF, 0);        // wake tid3
    iss(1, 'h10C, 'hFF); iss(2, 'h10, 'hFF);  iss(3, 'hC, 'hFF);   iss(4, 'h10, 'hFF);
    add(0, 0, 0, 'hB, 'hB, 0, 0, 0, 1, 5, 'h20C, 'hFF, 0);     // block+wake tid3
    iss(6, 'h10, 'hFF);  iss(7, 'h10, 'hFF);  iss(0, 'h14, 'hFF);  iss(1, 'h110, 'hFF);
    iss(2, 'h14, 'hFF);
    add(0, 0, 0, 'hB, 'hB, 0, 0, 0, 1, 3, 'h10, 'hFF, 0);      // block+wake tid3 on its own slot
    add(0, 0, 0, 'hC, 0, 0, 0, 0, 1, 5, 'h210, 'hEF, 0);       // block tid4 on its own slot
    add(0, 0, 0, 0, 'hC, 0, 0, 0, 1, 6, 'h14, 'hFF, 0);
    iss(7, 'h14, 'hFF);  iss(0, 'h18, 'hFF);  iss(1, 'h114, 'hFF); iss(2, 'h18, 'hFF);
    iss(3, 'h14, 'hFF);  iss(4, 'h14, 'hFF);

    // Phase B: lone thread 2, cooldown gap with and without stall, then halt everything.
    add(1, 0, 'h04, 0, 0, 0, 0, 0, 0, 0, 0, 'h04, 0);
    iss(2, 0, 'h04);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 'h04, 0);
    for (int i = 0; i < 4; i++) bub('h04, 0);
    iss(2, 'h4, 'h04);
    for (int i = 0; i < 4; i++) bub('h04, 0);
    iss(2, 'h8, 'h04);
    add(0, 0, 0, 0, 0, 'hA, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h8, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h9, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 3; t < 7; t++) add(0, 0, 0, 0, 0, 8 + t, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'hF, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);             // start after halt ignored

    // Phase D: stall mid-stream with a redirect landing during the stall.
    add(1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 0);
    iss(0, 0, 'hFF);
    iss(1, 0, 'hFF);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hFF, 0);
    add(0, 1, 0, 0, 0, 0, 'h8, 'h300, 1, 1, 0, 'hFF, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hFF, 0);
    for (int t = 2; t < 8; t++) iss(t, 0, 'hFF);
    iss(0, 'h300, 'hFF);
    iss(1, 'h4, 'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i),  32'(issue_valid_o), 32'(v.ev));
      chk($sformatf("v%0d bubble", i), 32'(bubble_o),      32'(!v.ev));
      chk($sformatf("v%0d mask", i),   32'(run_mask_o),    32'(v.em));
      chk($sformatf("v%0d halted", i), 32'(all_halted_o),  32'(v.eh));
      if (v.ev) begin
        chk($sformatf("v%0d tid", i), 32'(issue_tid_o), 32'(v.et));
        chk($sformatf("v%0d pc", i),  issue_pc_o,       v.ep);
      end
    end
    clear_inputs();

    // Asynchronous reset between edges while an issue is being presented.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    chk("async held valid", 32'(issue_valid_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start-to-issue latency for a single thread.
    start_i = 8'h40;
    @(posedge clk);
    #1;
    chk("start edge valid", 32'(issue_valid_o), 32'h0);
    chk("start edge mask",  32'(run_mask_o),    32'h40);
    start_i = '0;
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (issue_valid_o) break;
    end
    chk("start latency", 32'(n), 32'd1);
    chk("start tid",     32'(issue_tid_o), 32'd6);
    chk("start pc",      issue_pc_o,       32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
